// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a..g} patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Counter width for n states, never narrower than one bit
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed seven-segment driver with frame-aligned value update
// and optional leading-zero blanking.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned CLK_DIV       = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned TW = clog2w(CLK_DIV);
    localparam int unsigned IW = clog2w(DIGITS);
    localparam int unsigned VW = 4 * DIGITS;

    logic [TW-1:0]     tick;
    logic [IW-1:0]     idx;
    logic [VW-1:0]     disp_val, pend_val;
    logic [DIGITS-1:0] disp_dp, pend_dp;
    logic              disp_blank, pend_blank;

    logic              tick_wrap_c, frame_end_c, accept_c, commit_c;
    logic [3:0]        nib_c;
    logic [6:0]        dec_seg_c;
    logic              dp_sel_c, lz_sel_c, lz_run_c, blank_c;

    assign tick_wrap_c = (tick == TW'(CLK_DIV - 1));
    assign frame_end_c = tick_wrap_c && (idx == IW'(DIGITS - 1));
    assign accept_c    = value_valid && value_ready;
    // value_ready low means the pending slot holds an uncommitted value
    assign commit_c    = frame_end_c && !value_ready;

    // Digit dwell counter and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_wrap_c) begin
            tick <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Pending slot and displayed value; commit only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            value_ready <= 1'b1;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend_blank  <= 1'b0;
            disp_val    <= '0;
            disp_dp     <= '0;
            disp_blank  <= BLANK_LEADING;
        end else if (commit_c) begin
            disp_val    <= pend_val;
            disp_dp     <= pend_dp;
            disp_blank  <= pend_blank;
            value_ready <= 1'b1;
        end else if (accept_c) begin
            pend_val    <= value;
            pend_dp     <= dp_mask;
            pend_blank  <= blank_en;
            value_ready <= 1'b0;
        end
    end

    // Select the current digit and decide whether it is a leading zero
    always_comb begin
        nib_c    = '0;
        dp_sel_c = 1'b0;
        lz_sel_c = 1'b0;
        lz_run_c = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lz_run_c = lz_run_c && (disp_val[4*i +: 4] == 4'h0);
            if (IW'(i) == idx) begin
                nib_c    = disp_val[4*i +: 4];
                dp_sel_c = disp_dp[i];
                lz_sel_c = lz_run_c;
            end
        end
        blank_c = disp_blank && (idx != '0) && lz_sel_c;
    end

    hex7seg_decode u_decode (
        .nibble (nib_c),
        .seg    (dec_seg_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= blank_c ? SEG_OFF : dec_seg_c;
            dp  <= ~dp_sel_c;
            an  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle-count reference model
// predicts every output cycle, a negedge monitor compares.
module tb_seg_display_scan;

    localparam int unsigned D  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned FR = D * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg_display_scan #(.DIGITS(D), .CLK_DIV(C), .BLANK_LEADING(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_en    (blank_en),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [6:0] ref_hex [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Reference model: digit and frame follow from edges counted since reset
    int          k;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp;
    logic        m_bl, p_bl, m_full;

    always @(posedge clk) begin
        exp_t e;
        int   d;
        if (rst) begin
            e      = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, ready: 1'b1};
            k      = 0;
            m_val  = '0;
            m_dp   = '0;
            m_bl   = 1'b1;
            m_full = 1'b0;
        end else begin
            k++;
            d     = ((k - 1) / C) % D;
            e.an  = ~(4'b0001 << d);
            e.seg = (m_bl && d > 0 && (m_val >> (4 * d)) == 16'h0) ? 7'h7F
                    : ref_hex[4'(m_val >> (4 * d))];
            e.dp  = ~m_dp[d];
            if ((k % FR) == 0 && m_full) begin
                m_val  = p_val;
                m_dp   = p_dp;
                m_bl   = p_bl;
                m_full = 1'b0;
            end else if (value_valid && !m_full) begin
                p_val  = value;
                p_dp   = dp_mask;
                p_bl   = blank_en;
                m_full = 1'b1;
            end
            e.ready = !m_full;
        end
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg",         16'(seg),         16'(e.seg));
            check("dp",          16'(dp),          16'(e.dp));
            check("an",          16'(an),          16'(e.an));
            check("value_ready", 16'(value_ready), 16'(e.ready));
        end
    end

    // Hold value_valid until a cycle with ready high has passed an edge
    task automatic offer(input logic [15:0] v, input logic [3:0] m, input logic b);
        bit r;
        int n = 0;
        value       = v;
        dp_mask     = m;
        blank_en    = b;
        value_valid = 1'b1;
        forever begin
            r = value_ready;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL handshake timeout at %0t: value_ready stuck at %b, expected 1", $time, value_ready);
                break;
            end
        end
        value_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FR + 6) @(negedge clk);

        // Mid-frame offer, then a second value held against back-pressure
        offer(16'h12AF, 4'b0010, 1'b0);
        offer(16'h5555, 4'b0000, 1'b0);
        repeat (2 * FR) @(negedge clk);

        offer(16'h0007, 4'b0000, 1'b1);
        repeat (2 * FR) @(negedge clk);
        offer(16'h0000, 4'b0100, 1'b1);
        repeat (2 * FR) @(negedge clk);

        repeat (12) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            offer(16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom), 1'($urandom));
        end
        repeat (2 * FR) @(negedge clk);

        // Reset with a value pending and the scan mid-digit
        offer(16'hBEEF, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FR + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
Parametrised, time-multiplexed seven-segment display controller. It drives the board's seg/dp/an pins from a hex value supplied by the CPU top level.
Generalises the fixed 8-digit driver in four ways:
- configurable digit count and refresh rate
- per-digit decimal points
- optional leading-zero blanking
- tear-free valid/ready value update that commits only at frame boundaries

Parameters:
DIGITS, 8, number of digits scanned (1..16)
CLK_DIV, 100000, clk cycles each digit is held (>=1)
BLANK_LEADING, 1, reset value of internal blank-enable; 0 shows all zeros

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value_valid  in  1  new display value offered
value_ready  out  1  block can accept value this cycle
value  in  4*DIGITS  hex nibbles, nibble i -> digit i (digit 0 rightmost)
dp_mask  in  DIGITS  decimal-point enables, sampled with value, 1 = lit
blank_en  in  1  leading-zero blanking enable, sampled with value
seg  out  7  segments active-low, seg[6]=a ... seg[0]=g
dp  out  1  decimal point, active-low
an  out  DIGITS  digit enables, active-low, one-hot-low when scanning

Behaviour:
- Reset (clk edge with rst=1):
  - seg=7'h7F, dp=1, an=all ones
  - tick=0, idx=0, disp_val=0, disp_dp=0, disp_blank=BLANK_LEADING
  - pending empty, value_ready=1
  - rst mid-transaction discards pending and displayed values.
- Tick counter: tick counts 0..CLK_DIV-1. On tick==CLK_DIV-1 it wraps to 0 and idx advances (DIGITS-1 wraps to 0). With CLK_DIV=1, idx advances every cycle.
- Frame boundary: cycle where tick==CLK_DIV-1 and idx==DIGITS-1.
- Handshake:
  - value_ready = ~pending_full (registered state, no combinational path from value_valid).
  - Accept when value_valid & value_ready: {value, dp_mask, blank_en} is captured into pending and pending_full=1 next cycle.
  - value_valid while ready=0 is ignored; the source must hold it.
- Commit:
  - At a frame boundary with pending_full=1, pending is copied to disp_* and pending_full clears.
  - The new value is used starting with digit 0 of the next frame.
  - A value accepted on a frame-boundary cycle is not committed that cycle; it waits for the next boundary.
  - Commit and accept never coincide, because ready=0 while pending is full. ready returns to 1 the cycle after commit.
- Outputs are registered, one cycle after idx/disp update:
  - an = ~(1<<idx)
  - seg = decode(disp_val nibble idx)
  - dp = ~disp_dp[idx]
- Blanking:
  - Digit i>0 is blanked (seg=7'h7F, dp still driven by dp mask) when disp_blank=1 and nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
- Decode, active-low, {a..g}:
  - 0=7E→01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Width rules:
  - tick width = clog2(CLK_DIV), minimum 1.
  - idx width = clog2(DIGITS), minimum 1.
  - DIGITS=1: idx constant 0; every tick wrap is a frame boundary.

Decomposition:
- Shared package seg_pkg:
  - 16-entry active-low segment constant table SEG_HEX
  - SEG_OFF=7'h7F
  - width helper function
- Sub-module hex7seg_decode: combinational, nibble in -> 7-bit active-low segments.
- Scanning, handshake and blanking logic stay in seg_display_scan.

Test Plan:
- Reset: DIGITS=4, CLK_DIV=4, hold rst 3 cycles -> seg=7F, dp=1, an=4'b1111, value_ready=1.
- Scan order: after reset release -> an cycles 1110,1101,1011,0111, each held exactly 4 clks, then wraps to 1110.
- Handshake and commit: offer value=16'h12AF, dp_mask=4'b0010, blank_en=0 mid-frame.
  - value_ready drops the next cycle.
  - Display stays 0000 until the boundary.
  - Next frame shows F(38), A(08), 2(12), 1(4F), with dp=0 only while an=1101.
  - value_ready returns to 1 the cycle after the boundary.
- Back-pressure: assert value_valid with 16'h5555 while pending is full -> not accepted. It is captured only after ready rises, and is displayed one frame later.
- Blanking: value=16'h0007, blank_en=1 -> digit 0 seg=0F; digits 1-3 seg=7F. value=16'h0000 -> digit 0 shows 0 (01), digits 1-3 blank.
- Reset mid-operation: rst asserted with pending full, mid-digit -> next cycle outputs at reset values, pending dropped, ready=1. After release, scanning restarts at an=1110 showing 0.
